// File: rtl/updown_mod_counter_pkg.sv
// Shared encodings for the up/down modulo counter: direction and bound mode.
package updown_mod_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..limit with wrap or saturate, synchronous load/enable,
// registered terminal-count pulse and combinational at-zero/at-limit status.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH              = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             at_zero,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;

  // Bounds are compared before any add/subtract, so nothing ever overflows WIDTH.
  always_comb begin
    cnt_nxt = counter;
    tc_nxt  = 1'b0;
    if (load) begin
      cnt_nxt = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (counter < limit) begin
          cnt_nxt = counter + ONE;
        end else begin
          tc_nxt  = 1'b1;
          cnt_nxt = (sat_mode == MODE_SAT) ? limit : '0;
        end
      end else begin
        if (counter > limit) begin
          // limit dropped below the count while heading down: clamp quietly
          cnt_nxt = limit;
        end else if (counter != '0) begin
          cnt_nxt = counter - ONE;
        end else begin
          tc_nxt  = 1'b1;
          cnt_nxt = (sat_mode == MODE_SAT) ? '0 : limit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= RST_CNT;
      tc      <= 1'b0;
    end else begin
      counter <= cnt_nxt;
      tc      <= tc_nxt;
    end
  end

  assign at_zero  = (counter == '0);
  assign at_limit = (counter == limit);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed-vector scoreboard bench: stimulus pushes hand-derived expectations,
// a monitor pops and compares them against the registered outputs each cycle.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, sat_mode, load;
  logic [3:0] load_val, limit;
  logic [3:0] counter;
  logic       tc, at_zero, at_limit;

  typedef struct {
    logic [3:0] c;
    logic       tc;
    logic       z;
    logic       l;
    int         id;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  updown_mod_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .sat_mode (sat_mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .counter  (counter),
    .tc       (tc),
    .at_zero  (at_zero),
    .at_limit (at_limit)
  );

  always #5 clk = ~clk;

  // Drive one edge of inputs; queue the state expected right after that edge.
  task automatic step(input logic r, input logic e, input logic u, input logic s,
                      input logic ld, input logic [3:0] lv, input logic [3:0] lim,
                      input logic [3:0] exp_c, input logic exp_tc);
    exp_t x;
    reset = r; en = e; up = u; sat_mode = s; load = ld; load_val = lv; limit = lim;
    @(posedge clk);
    #1;
    x.c  = exp_c;
    x.tc = exp_tc;
    x.z  = (exp_c == 4'd0);
    x.l  = (exp_c == lim);
    x.id = n_step;
    q.push_back(x);
    n_step++;
    #3;
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle away from the edge.
  always @(posedge clk) begin
    exp_t x;
    #2;
    while (q.size() > 0) begin
      x = q.pop_front();
      n_chk++;
      if (counter !== x.c) begin
        n_fail++;
        $display("FAIL counter step %0d: got %0d, expected %0d", x.id, counter, x.c);
      end
      n_chk++;
      if (tc !== x.tc) begin
        n_fail++;
        $display("FAIL tc step %0d: got %b, expected %b", x.id, tc, x.tc);
      end
      n_chk++;
      if (at_zero !== x.z) begin
        n_fail++;
        $display("FAIL at_zero step %0d: got %b, expected %b", x.id, at_zero, x.z);
      end
      n_chk++;
      if (at_limit !== x.l) begin
        n_fail++;
        $display("FAIL at_limit step %0d: got %b, expected %b", x.id, at_limit, x.l);
      end
    end
  end

  initial begin
    //   r  en up sat ld lv    lim    cnt    tc
    // 1. reset for two edges, then down-wrap over 0..15
    step(1, 1, 1, 0, 0, 4'd0, 4'd15, 4'd0, 0);
    step(1, 0, 0, 0, 0, 4'd0, 4'd15, 4'd0, 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd15, 4'd15, 1);
    for (int v = 14; v >= 0; v--)
      step(0, 1, 0, 0, 0, 4'd0, 4'd15, 4'(v), 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd15, 4'd15, 1);

    // 2. limit 9 up-wrap: 15 > 9 wraps to 0 first, then 1..9, 0 (tc), 1
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd0, 1);
    for (int v = 1; v <= 9; v++)
      step(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'(v), 0);
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd0, 1);
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd1, 0);

    // 3. saturate at limit 5 going up, then at 0 going down
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 4'd2, 0);
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 4'd3, 0);
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 4'd4, 0);
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 4'd5, 0);
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 4'd5, 1);
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 4'd5, 1);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd4, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd3, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd2, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd1, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd0, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd0, 1);
    step(0, 1, 0, 1, 0, 4'd0, 4'd5, 4'd0, 1);

    // 4. load clamps to limit, beats en, loses to reset
    step(0, 1, 1, 0, 1, 4'd12, 4'd9, 4'd9, 0);
    step(0, 1, 1, 0, 1, 4'd3,  4'd9, 4'd3, 0);
    step(1, 1, 1, 0, 1, 4'd7,  4'd9, 4'd0, 0);

    // 5. tc clears on hold; direction flips each cycle
    step(0, 0, 0, 1, 1, 4'd6, 4'd6, 4'd6, 0);
    step(0, 1, 1, 1, 0, 4'd0, 4'd6, 4'd6, 1);
    step(0, 0, 1, 1, 0, 4'd0, 4'd6, 4'd6, 0);
    step(0, 0, 0, 0, 0, 4'd0, 4'd9, 4'd6, 0);
    step(0, 0, 1, 0, 0, 4'd0, 4'd9, 4'd6, 0);
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd7, 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd9, 4'd6, 0);
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd7, 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd9, 4'd6, 0);

    // 6. limit lowered below the count, all four direction/mode combinations
    step(0, 0, 0, 0, 1, 4'd12, 4'd15, 4'd12, 0);
    step(0, 1, 1, 0, 0, 4'd0,  4'd8,  4'd0,  1);
    step(0, 0, 0, 0, 1, 4'd12, 4'd15, 4'd12, 0);
    step(0, 1, 0, 0, 0, 4'd0,  4'd8,  4'd8,  0);
    step(0, 0, 0, 0, 1, 4'd12, 4'd15, 4'd12, 0);
    step(0, 1, 1, 1, 0, 4'd0,  4'd8,  4'd8,  1);
    step(0, 0, 0, 0, 1, 4'd12, 4'd15, 4'd12, 0);
    step(0, 1, 0, 1, 0, 4'd0,  4'd8,  4'd8,  0);
    // reset mid-count, then counting resumes
    step(0, 1, 0, 0, 0, 4'd0,  4'd8,  4'd7,  0);
    step(1, 1, 0, 0, 0, 4'd0,  4'd8,  4'd0,  0);
    step(0, 1, 1, 0, 0, 4'd0,  4'd8,  4'd1,  0);

    // limit 0: pinned at 0, tc every enabled cycle
    step(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    step(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    step(0, 1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 1);
    step(0, 1, 1, 1, 0, 4'd0, 4'd0, 4'd0, 1);

    // let the monitor drain, then make sure every expectation was consumed
    en = 1'b0; load = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
